// File: rtl/prog_loader.sv
// Program loader: receives a length-prefixed byte stream and writes it,
// big-endian packed, into instruction RAM as 32-bit words. Once the last
// word has landed the processor is released (working); a bad length
// (0 or more than 512 words) parks the block in a sticky error state.
//
// Handshake: a byte moves only on a rising edge where in_valid and in_ready
// are both 1. in_ready depends only on the current state, never on in_valid.
// If in_valid is high while in_ready is low, the byte stays with the source
// and is not consumed.
module prog_loader (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic [8:0]  addr,
  output logic        wr,
  output logic [31:0] wdata,
  output logic        working,
  output logic        err,
  output logic [9:0]  words_loaded
);

  typedef enum logic [2:0] {
    LEN_HI = 3'd0,
    LEN_LO = 3'd1,
    DATA   = 3'd2,
    FLUSH  = 3'd3,
    RUN    = 3'd4,
    ERR    = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] len_q, len_d;        // program length in 32-bit words
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [23:0] shift_q, shift_d;    // first three bytes of the word in flight
  logic        wr_q, wr_d;
  logic [8:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [9:0]  words_q, words_d;    // also the index of the next word to write

  logic        accept;
  logic [15:0] len_full;
  logic        last_word;

  assign in_ready     = (state_q == LEN_HI) || (state_q == LEN_LO) || (state_q == DATA);
  assign accept       = in_valid && in_ready;
  assign len_full     = {len_q[15:8], in_data};
  assign last_word    = ({6'd0, words_q} == (len_q - 16'd1));

  assign wr           = wr_q;
  assign addr         = addr_q;
  assign wdata        = wdata_q;
  assign words_loaded = words_q;
  assign working      = (state_q == RUN);
  assign err          = (state_q == ERR);

  // State register and datapath registers; reset wins over any incoming byte.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= LEN_HI;
      len_q      <= 16'd0;
      byte_cnt_q <= 2'd0;
      shift_q    <= 24'd0;
      wr_q       <= 1'b0;
      addr_q     <= 9'd0;
      wdata_q    <= 32'd0;
      words_q    <= 10'd0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      words_q    <= words_d;
    end
  end

  // Next-state and datapath updates. wr is a one-cycle pulse; addr/wdata
  // hold the last written word between pulses.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    wr_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    words_d    = words_q;

    case (state_q)
      LEN_HI: begin
        if (accept) begin
          len_d[15:8] = in_data;
          state_d     = LEN_LO;
        end
      end
      LEN_LO: begin
        if (accept) begin
          len_d[7:0] = in_data;
          if ((len_full == 16'd0) || (len_full > 16'd512)) state_d = ERR;
          else                                             state_d = DATA;
        end
      end
      DATA: begin
        if (accept) begin
          if (byte_cnt_q == 2'd3) begin
            wr_d       = 1'b1;
            addr_d     = words_q[8:0];
            wdata_d    = {shift_q, in_data};
            words_d    = words_q + 10'd1;
            byte_cnt_d = 2'd0;
            if (last_word) state_d = FLUSH;
          end else begin
            shift_d    = {shift_q[15:0], in_data};
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end
      end
      FLUSH:   state_d = RUN;   // final wr pulse is on the bus this cycle
      RUN:     state_d = RUN;
      ERR:     state_d = ERR;
      default: state_d = LEN_HI;
    endcase
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader. Expected RAM writes are queued as the
// stream is driven and popped by a monitor whenever wr pulses.
module tb_prog_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_ready;
  logic [8:0]  addr;
  logic        wr;
  logic [31:0] wdata;
  logic        working;
  logic        err;
  logic [9:0]  words_loaded;

  logic [40:0] exp_q[$];   // {addr, wdata}
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          last_wr_cyc = -10;
  logic        prev_wr = 1'b0;

  prog_loader dut (
    .clock        (clock),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .addr         (addr),
    .wr           (wr),
    .wdata        (wdata),
    .working      (working),
    .err          (err),
    .words_loaded (words_loaded)
  );

  // Clock and cycle counter
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: every wr pulse must match the oldest queued write.
  always @(negedge clock) begin
    logic [40:0] e;
    if (wr) begin
      chk("wr_while_working", working, 1'b0);
      chk("wr_consecutive", prev_wr, 1'b0);
      if (exp_q.size() == 0) begin
        chk("unexpected_wr", wr, 1'b0);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", {23'd0, addr}, {23'd0, e[40:32]});
        chk("wr_wdata", wdata, e[31:0]);
        last_wr_cyc = cyc;
      end
    end
    prev_wr = wr;
  end

  // Driver tasks: all start and end 1 time unit after a rising edge.
  task automatic send_byte(input logic [7:0] b);
    int  n;
    bit  done;
    n    = 0;
    done = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!done) begin
      @(negedge clock);
      if (in_ready) done = 1;
      else begin
        n++;
        if (n > 50) begin
          chk("send_timeout", in_ready, 1'b1);
          done = 1;
        end
      end
    end
    @(posedge clock); #1;
  endtask

  task automatic send_byte_gap(input logic [7:0] b);
    repeat ($urandom_range(0, 2)) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      @(posedge clock); #1;
    end
    send_byte(b);
  endtask

  task automatic send_len(input logic [15:0] l);
    send_byte(l[15:8]);
    send_byte(l[7:0]);
  endtask

  task automatic send_word(input logic [8:0] idx, input logic [31:0] w, input bit gaps);
    exp_q.push_back({idx, w});
    for (int i = 3; i >= 0; i--) begin
      if (gaps) send_byte_gap(w[i*8 +: 8]);
      else      send_byte(w[i*8 +: 8]);
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic do_reset(input bit with_byte, input logic [7:0] b);
    reset    = 1'b1;
    in_valid = with_byte;
    in_data  = b;
    @(posedge clock); #1;
    reset    = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    @(negedge clock);
    chk({tag, "_in_ready"}, in_ready, 1'b1);
    chk({tag, "_wr"}, wr, 1'b0);
    chk({tag, "_addr"}, {23'd0, addr}, 32'd0);
    chk({tag, "_wdata"}, wdata, 32'd0);
    chk({tag, "_working"}, working, 1'b0);
    chk({tag, "_err"}, err, 1'b0);
    chk({tag, "_words"}, {22'd0, words_loaded}, 32'd0);
    @(posedge clock); #1;
  endtask

  task automatic wait_working(input string tag);
    int n;
    n = 0;
    idle();
    while (n < 100) begin
      @(negedge clock);
      if (working) break;
      n++;
    end
    chk({tag, "_working"}, working, 1'b1);
    chk({tag, "_latency"}, cyc - last_wr_cyc, 32'd1);
    chk({tag, "_exp_drained"}, exp_q.size(), 32'd0);
    @(posedge clock); #1;
  endtask

  initial begin
    logic [31:0] w;

    // Power-on reset
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    check_reset_vals("por");

    // Two-word reference stream, one byte per cycle
    send_len(16'd2);
    send_word(9'd0, 32'h10F00080, 1'b0);
    send_word(9'd1, 32'h20010000, 1'b0);
    wait_working("two_word");
    chk("two_word_count", {22'd0, words_loaded}, 32'd2);
    chk("two_word_addr_hold", {23'd0, addr}, 32'd1);
    chk("two_word_wdata_hold", wdata, 32'h20010000);

    // Bytes offered in RUN are ignored
    in_valid = 1'b1;
    in_data  = 8'h55;
    repeat (5) begin
      @(negedge clock);
      chk("run_in_ready", in_ready, 1'b0);
    end
    @(posedge clock); #1;
    idle();
    @(negedge clock);
    chk("run_count_stable", {22'd0, words_loaded}, 32'd2);
    chk("run_still_working", working, 1'b1);
    @(posedge clock); #1;

    // Zero length -> sticky error
    do_reset(1'b0, 8'h00);
    send_len(16'd0);
    @(negedge clock);
    chk("len0_err", err, 1'b1);
    chk("len0_in_ready", in_ready, 1'b0);
    chk("len0_working", working, 1'b0);
    @(posedge clock); #1;
    in_valid = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    idle();
    @(negedge clock);
    chk("len0_err_sticky", err, 1'b1);
    chk("len0_words", {22'd0, words_loaded}, 32'd0);
    @(posedge clock); #1;

    // 513 words -> error
    do_reset(1'b0, 8'h00);
    send_len(16'd513);
    @(negedge clock);
    chk("len513_err", err, 1'b1);
    chk("len513_working", working, 1'b0);
    @(posedge clock); #1;

    // Maximum length, 512 words back to back
    do_reset(1'b0, 8'h00);
    send_len(16'd512);
    for (int i = 0; i < 512; i++) begin
      w = $urandom;
      send_word(9'(i), w, 1'b0);
    end
    wait_working("max_len");
    chk("max_len_count", {22'd0, words_loaded}, 32'd512);
    chk("max_len_last_addr", {23'd0, addr}, 32'd511);
    chk("max_len_err", err, 1'b0);

    // Three words with random in_valid gaps
    do_reset(1'b0, 8'h00);
    send_len(16'd3);
    send_word(9'd0, 32'hDEADBEEF, 1'b1);
    send_word(9'd1, 32'h01234567, 1'b1);
    send_word(9'd2, 32'h89ABCDEF, 1'b1);
    wait_working("gaps");
    chk("gaps_count", {22'd0, words_loaded}, 32'd3);

    // Reset mid-load, with a byte offered in the reset cycle
    do_reset(1'b0, 8'h00);
    send_len(16'd2);
    send_word(9'd0, 32'hCAFEF00D, 1'b0);
    send_byte(8'h11);
    send_byte(8'h22);
    chk("midload_word0_written", exp_q.size(), 32'd0);
    do_reset(1'b1, 8'h5A);
    check_reset_vals("midload");
    send_len(16'd1);
    send_word(9'd0, 32'hAABBCCDD, 1'b0);
    wait_working("after_reset");
    chk("after_reset_count", {22'd0, words_loaded}, 32'd1);
    chk("after_reset_wdata", wdata, 32'hAABBCCDD);

    repeat (3) @(posedge clock);
    chk("final_exp_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
